// File: rtl/if_id_seg_queue.sv
// IF->ID fetch queue: DEPTH-entry FIFO feeding a registered output segment.
// An empty queue with ID free bypasses straight into the output register, so the latency matches a plain IF/ID register.
module if_id_seg_queue #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_ready,
  input  logic                       bubbleD,
  input  logic                       flushD,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  logic w_push_acc;
  logic w_nonempty;
  logic w_pop;
  logic w_bypass;
  logic w_store;

  // Ready is purely occupancy based; a same-cycle pop does not open a slot.
  assign push_ready = (r_count < DEPTH_C);
  assign w_push_acc = push_valid && push_ready && !flushD;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = !flushD && !bubbleD && w_nonempty;
  assign w_bypass   = !bubbleD && !w_nonempty && w_push_acc;
  assign w_store    = w_push_acc && !w_bypass;

  always_ff @(posedge clk) begin
    if (w_store && !rst) begin
      r_mem[r_tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Flush outranks a stall here, unlike the old segment register.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (!bubbleD) begin
      if (w_nonempty) begin
        r_out_data  <= r_mem[r_head];
        r_out_valid <= 1'b1;
      end else if (w_push_acc) begin
        r_out_data  <= push_data;
        r_out_valid <= 1'b1;
      end else begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign count     = r_count;
endmodule

// File: tb/tb_if_id_seg_queue.sv
// Directed scenarios plus random traffic against a queue-based model of the IF->ID fetch queue.
module tb_if_id_seg_queue;
  localparam int DATA_W = 34;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push_valid = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic              push_ready;
  logic              bubbleD = 1'b0;
  logic              flushD = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [CW-1:0]     count;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_out_data;
  logic              m_out_valid;
  bit                m_known = 1'b0;

  if_id_seg_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .bubbleD(bubbleD), .flushD(flushD),
    .out_data(out_data), .out_valid(out_valid), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of inputs, advances the model by the behavioural rules, and compares.
  task automatic step(input logic r, input logic fl, input logic bub, input logic pv,
                      input logic [DATA_W-1:0] pd, input string tag);
    bit acc;
    rst = r; flushD = fl; bubbleD = bub; push_valid = pv; push_data = pd;
    #1;
    if (m_known) chk({tag, ".ready"}, DATA_W'(push_ready), DATA_W'(m_q.size() < DEPTH));
    @(posedge clk);
    acc = pv && (m_q.size() < DEPTH);
    if (r || fl) begin
      m_q.delete();
      m_out_data = '0; m_out_valid = 1'b0;
    end else if (bub) begin
      if (acc) m_q.push_back(pd);
    end else if (m_q.size() > 0) begin
      m_out_data = m_q.pop_front(); m_out_valid = 1'b1;
      if (acc) m_q.push_back(pd);
    end else if (acc) begin
      m_out_data = pd; m_out_valid = 1'b1;
    end else begin
      m_out_data = '0; m_out_valid = 1'b0;
    end
    if (r) m_known = 1'b1;
    #1;
    if (m_known) begin
      chk({tag, ".data"},  out_data, m_out_data);
      chk({tag, ".valid"}, DATA_W'(out_valid), DATA_W'(m_out_valid));
      chk({tag, ".count"}, DATA_W'(count), DATA_W'(m_q.size()));
      $display("%s: rst=%0b fl=%0b bub=%0b pv=%0b pd=%h -> out=%h v=%0b cnt=%0d",
               tag, r, fl, bub, pv, pd, out_data, out_valid, count);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    // Reset then stream with single-cycle bypass latency
    step(1, 0, 0, 0, '0, "reset");
    chk("reset.ready", DATA_W'(push_ready), DATA_W'(1));
    step(0, 0, 0, 1, 34'h100, "stream0");
    chk("stream0.abs", out_data, 34'h100);
    step(0, 0, 0, 1, 34'h104, "stream1");
    step(0, 0, 0, 1, 34'h108, "stream2");
    chk("stream2.abs", out_data, 34'h108);
    step(0, 0, 0, 0, '0, "idle");

    // Stall and fill to full; the fifth push is refused
    step(0, 0, 0, 1, 34'h3_0000_0055, "prime");
    step(0, 0, 1, 1, 34'h0A, "fillA");
    step(0, 0, 1, 1, 34'h0B, "fillB");
    step(0, 0, 1, 1, 34'h0C, "fillC");
    step(0, 0, 1, 1, 34'h0D, "fillD");
    chk("full.ready", DATA_W'(push_ready), DATA_W'(0));
    step(0, 0, 1, 1, 34'h0E, "fillE");
    chk("full.hold", out_data, 34'h3_0000_0055);

    // Drain in order, then a bubble
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0, "drain");
    chk("drain.empty", DATA_W'(out_valid), DATA_W'(0));

    // Flush outranks bubble and drops the same-cycle push
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, DATA_W'(34'h10 + i), "pre_flush");
    step(0, 1, 1, 1, 34'h200, "flush");
    chk("flush.count", DATA_W'(count), DATA_W'(0));
    step(0, 0, 0, 0, '0, "post_flush");

    // Reach count=2 with head=3, then push+pop across the pointer wrap
    step(1, 0, 0, 0, '0, "wrap_rst");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, DATA_W'(34'h20 + i), "wrap_fill");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, "wrap_pop");
    step(0, 0, 1, 1, 34'h24, "wrap_fill2");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, DATA_W'(34'h30 + i), "wrap_stream");
    chk("wrap.count", DATA_W'(count), DATA_W'(2));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, "wrap_drain");

    // Reset while full and stalled
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, DATA_W'(34'h40 + i), "mid_fill");
    step(1, 0, 1, 1, 34'h99, "mid_rst");
    chk("mid_rst.ready", DATA_W'(push_ready), DATA_W'(1));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rd = {2'($urandom), 32'($urandom)};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), rd, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_seg_queue.md
Name: if_id_seg_queue

Overview:
- Parametrised successor to the single-entry IF/ID segment register.
- Carries a generic payload (PC, prediction bits, etc.) from IF to ID through a DEPTH-entry fetch queue followed by an output segment register.
- IF can keep fetching while ID is stalled; flush discards everything in flight.
- Sits between the PC/fetch stage and the decode stage, where the old IF/ID PC register was.

Parameters:
- DATA_W, 34, payload width in bits (default: 32-bit PC plus two prediction bits).
- DEPTH, 4, queue entries ahead of the output register; power of two, >= 2.

Ports:
- clk  in  1  core clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- push_valid  in  1  IF presents a valid payload this cycle.
- push_data  in  DATA_W  payload from IF.
- push_ready  out  1  queue can accept; combinational, = (count < DEPTH).
- bubbleD  in  1  ID stall: hold output register, no pop.
- flushD  in  1  discard queue and output register contents.
- out_data  out  DATA_W  registered payload to ID.
- out_valid  out  1  out_data holds a real entry (0 = bubble).
- count  out  $clog2(DEPTH+1)  number of occupied queue entries; the output register is not counted.

Behaviour:
- Reset (rst=1 at posedge): out_data=0, out_valid=0, count=0, head/tail pointers=0. Reset has highest priority.
- A push is accepted only when push_valid && push_ready && !flushD.
- Priority is rst > flushD > bubbleD.
  - flushD overrides bubbleD; this deliberately differs from the old register, where bubble masked flush.
- flushD=1 (rst=0): queue emptied (count=0, pointers reset), out_data=0, out_valid=0. Any same-cycle push is dropped.
- bubbleD=1 (no rst/flush):
  - out_data and out_valid hold.
  - An accepted push is written at tail; tail increments; count increments.
- bubbleD=0 (no rst/flush), output register update:
  - count>0: pop. out_data <= queue[head], out_valid <= 1, head increments.
  - count==0 and accepted push: bypass. out_data <= push_data, out_valid <= 1. The queue is untouched.
    - Latency IF->ID is 1 cycle, identical to the old segment register.
  - count==0, no push: out_data <= 0, out_valid <= 0 (bubble inserted).
- bubbleD=0 (no rst/flush), queue update:
  - An accepted push with count>0 is written at tail.
  - Pop and push in the same cycle: count unchanged. Pop only: count-1. Push only (non-bypass): count+1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Ordering: entries leave in strict push order.
- Full condition:
  - count==DEPTH drops push_ready to 0.
  - push_ready does not look ahead at a same-cycle pop.
  - Total in-flight capacity is DEPTH+1 (queue plus output register).
- Empty-to-nonempty with bubbleD=0 and push goes to bypass, never through storage.
- count never exceeds DEPTH and never underflows. No X on any output after reset.
- Storage array contents need no reset; only pointers, count and the output register are reset.

Test Plan:
- Reset then stream: rst 1 cycle, then push 0x100,0x104,0x108 on consecutive cycles with bubbleD=0. Required response:
  - out_data = 0x100/0x104/0x108 one cycle after each push.
  - out_valid=1 for those cycles; count stays 0 throughout.
- Stall fill to full: bubbleD=1 and push 5 payloads (A..E) with DEPTH=4. Required response:
  - count goes 1,2,3,4 and push_ready=0 after the 4th; E is not accepted.
  - out_data holds its prior value throughout.
- Drain after stall: from full (A..D), bubbleD=0, no pushes. Required response:
  - out_data = A,B,C,D on successive cycles, then 0 with out_valid=0.
  - count goes 3,2,1,0.
- Flush beats bubble: count=3, bubbleD=1, flushD=1, push_valid=1 with 0x200. Required response:
  - Next cycle: count=0, out_data=0, out_valid=0, and 0x200 is lost.
- Simultaneous push and pop with wrap: start with count=2 and head=3, bubbleD=0, push for 6 cycles. Required response:
  - count stays 2; pointers wrap past 3->0.
  - Output order equals push order with no duplicates or gaps.
- Reset mid-operation: count=4, bubbleD=1, assert rst with flushD=0. Required response:
  - All outputs zero and count=0 next cycle; push_ready=1.
